// File: rtl/nic_pkg.sv
// Shared NIC types: the ring packet format and the injection arbiter state encoding.
package nic_pkg;

  localparam int ARB_MAX_REQ = 8;

  typedef struct packed {
    logic [5:0]  did;
    logic [5:0]  sid;
    logic [3:0]  age;
    logic [31:0] data;
  } packet_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rf68000_ring_inject_arb_if.sv
// Local requester bundle for the ring injection arbiter.
interface rf68000_ring_inject_arb_if #(
  parameter int N_REQ = 4
);
  import nic_pkg::*;

  // Handshake: requester k raises req_i[k] with pkt_i[k] and holds both stable until
  // the cycle in which ack_o[k]=1; the packet transfers in that cycle.
  logic [N_REQ-1:0]    req_i;
  packet_t [N_REQ-1:0] pkt_i;
  logic [N_REQ-1:0]    ack_o;

  modport master (output req_i, output pkt_i, input ack_o);
  modport slave  (input req_i, input pkt_i, output ack_o);

endinterface

// File: rtl/rf68000_rr_arb.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping.
module rf68000_rr_arb #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);

  function automatic logic [PW-1:0] rot(input logic [PW-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!vld_o && req_i[rot(ptr_i, i)]) begin
        vld_o                 = 1'b1;
        gnt_o[rot(ptr_i, i)]  = 1'b1;
        idx_o                 = rot(ptr_i, i);
      end
    end
  end

endmodule

// File: rtl/rf68000_ring_inject_arb.sv
// Request-ring injection arbiter: forwards ring traffic and injects one held local packet
// into empty slots. Define RING_INJ_ARB_STATS_EN to build the inject/drop counters.
module rf68000_ring_inject_arb
  import nic_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int INJ_TIMEOUT = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [5:0]                  id_i,
  rf68000_ring_inject_arb_if.slave    req_if,
  input  packet_t                     ring_pkt_i,
  output packet_t                     ring_pkt_o,
  output logic                        busy_o,
  output logic                        stall_o,
  output logic [31:0]                 inj_cnt_o,
  output logic [15:0]                 drop_cnt_o,
  output arb_state_t                  state_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(INJ_TIMEOUT + 2);
  localparam logic [WW-1:0] WAIT_MAX = WW'(INJ_TIMEOUT + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  packet_t          hold_q, hold_d;
  packet_t          ring_q, ring_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WW-1:0]    wait_q, wait_d;

  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    win_idx;
  logic             win_vld;
  packet_t          win_pkt;
  logic             inject, free, take, drop, keep;

  rf68000_rr_arb #(.N(N_REQ), .PW(PW)) u_rr_arb (
    .req_i (req_if.req_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  // The hold register frees up in the same cycle it injects, so a new grant can follow at once.
  assign inject  = (state_q == ST_HOLD) && (ring_pkt_i.did == 6'd0);
  assign free    = (state_q == ST_IDLE) || inject;
  assign take    = free && win_vld && !rst_i;
  assign win_pkt = req_if.pkt_i[win_idx];
  assign drop    = take && (win_pkt.did == 6'd0);
  assign keep    = take && (win_pkt.did != 6'd0);

  assign req_if.ack_o = take ? gnt : '0;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    ring_d  = ring_pkt_i;
    if (inject) begin
      ring_d     = hold_q;
      ring_d.sid = id_i;
      ring_d.age = '0;
      state_d    = ST_IDLE;
      hold_d     = '0;
    end
    if (take) ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    if (keep) begin
      hold_d  = win_pkt;
      state_d = ST_HOLD;
    end
    if ((state_q == ST_IDLE) || inject) wait_d = '0;
    else if (wait_q != WAIT_MAX)        wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      ring_q  <= '0;
      ptr_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ring_q  <= ring_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
    end
  end

  assign ring_pkt_o = ring_q;
  assign busy_o     = (state_q == ST_HOLD);
  assign stall_o    = (wait_q > WW'(INJ_TIMEOUT));
  assign state_o    = arb_state_t'(state_q);

`ifdef RING_INJ_ARB_STATS_EN
  logic [31:0] inj_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inj_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (inject) inj_cnt_q  <= inj_cnt_q + 32'd1;
      if (drop)   drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign inj_cnt_o  = inj_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`else
  assign inj_cnt_o  = '0;
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rf68000_ring_inject_arb.sv
// Directed bench for rf68000_ring_inject_arb: reset, single inject, fairness, ring-full stall,
// back-to-back, drop and asynchronous reset while holding.
module tb_rf68000_ring_inject_arb;
  import nic_pkg::*;

`ifdef RING_INJ_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [5:0] NODE_ID = 6'h2A;

  logic        clk;
  logic        rst;
  logic [5:0]  id;
  packet_t     ring_in;
  packet_t     ring_out;
  logic        busy;
  logic        stall;
  logic [31:0] inj_cnt;
  logic [15:0] drop_cnt;
  arb_state_t  state;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];

  rf68000_ring_inject_arb_if #(.N_REQ(4)) req_if ();

  rf68000_ring_inject_arb #(.N_REQ(4), .INJ_TIMEOUT(255)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .id_i       (id),
    .req_if     (req_if),
    .ring_pkt_i (ring_in),
    .ring_pkt_o (ring_out),
    .busy_o     (busy),
    .stall_o    (stall),
    .inj_cnt_o  (inj_cnt),
    .drop_cnt_o (drop_cnt),
    .state_o    (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_if.req_i   = '0;
    ring_in        = '0;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // drivers
  task automatic drive_pkt(input logic [1:0] k, input logic [5:0] did, input logic [31:0] data);
    packet_t p;
    p      = '0;
    p.did  = did;
    p.sid  = 6'h3F;
    p.age  = 4'hF;
    p.data = data;
    req_if.pkt_i[k] = p;
  endtask

  task automatic drive_ring(input logic [5:0] did, input logic [31:0] data);
    ring_in      = '0;
    ring_in.did  = did;
    ring_in.sid  = 6'h09;
    ring_in.age  = 4'h3;
    ring_in.data = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_pkt(2'd0, 6'd1, 32'h1);
    drive_pkt(2'd1, 6'd2, 32'h2);
    drive_pkt(2'd2, 6'd3, 32'h3);
    drive_pkt(2'd3, 6'd4, 32'h4);
    req_if.req_i = 4'b1111;
    ring_in = '0;
    step();
    checks++; if (req_if.ack_o !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b exp 0000", req_if.ack_o); end
    checks++; if (ring_out !== packet_t'('0)) begin errors++; $display("FAIL reset_ring: got %h exp 0", ring_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
    checks++; if (state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
    checks++; if (inj_cnt !== 32'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", inj_cnt, drop_cnt); end
    req_if.req_i = '0;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    drive_pkt(2'd0, 6'd62, 32'hA5A5_0001);
    req_if.req_i = 4'b0001;
    #1;
    checks++; if (req_if.ack_o !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b exp 0001", req_if.ack_o); end
    step();
    req_if.req_i = '0;
    checks++; if (busy !== 1'b1 || state !== HOLD) begin errors++; $display("FAIL single_hold: got busy=%b st=%0d exp 1/1", busy, state); end
    step();
    checks++; if (ring_out.did !== 6'd62 || ring_out.sid !== NODE_ID || ring_out.age !== 4'd0 || ring_out.data !== 32'hA5A5_0001)
      begin errors++; $display("FAIL single_out: got %h exp did=3e sid=2a age=0 data=a5a50001", ring_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_free: got %b exp 0", busy); end
    checks++; if (inj_cnt !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL single_inj_cnt: got %0d exp %0d", inj_cnt, STATS); end
  endtask

  task automatic test_fairness();
    logic [5:0] exp_did;
    do_reset();
    for (int k = 0; k < 4; k++) drive_pkt(2'(k), 6'(k + 1), 32'(k));
    req_if.req_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (req_if.ack_o !== 4'(1 << (i % 4))) begin errors++; $display("FAIL fair_ack[%0d]: got %b exp %b", i, req_if.ack_o, 4'(1 << (i % 4))); end
      exp_q.push_back(6'((i % 4) + 1));
      @(posedge clk);
      #1;
      if (i >= 1) begin
        exp_did = exp_q.pop_front();
        checks++; if (ring_out.did !== exp_did) begin errors++; $display("FAIL fair_out[%0d]: got %0d exp %0d", i, ring_out.did, exp_did); end
      end
    end
    req_if.req_i = '0;
    step();
    exp_did = exp_q.pop_front();
    checks++; if (ring_out.did !== exp_did) begin errors++; $display("FAIL fair_out_last: got %0d exp %0d", ring_out.did, exp_did); end
  endtask

  task automatic test_ring_full();
    packet_t exp_ring;
    do_reset();
    drive_ring(6'd5, 32'h5555_5555);
    exp_ring = ring_in;
    drive_pkt(2'd0, 6'd7, 32'h7777_0000);
    req_if.req_i = 4'b0001;
    step();
    req_if.req_i = '0;
    for (int i = 0; i < 255; i++) step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_stall_255: got %b exp 0", stall); end
    checks++; if (ring_out !== exp_ring) begin errors++; $display("FAIL full_passthru: got %h exp %h", ring_out, exp_ring); end
    drive_pkt(2'd1, 6'd9, 32'h9999_0000);
    req_if.req_i = 4'b0010;
    #1;
    checks++; if (req_if.ack_o !== 4'b0000) begin errors++; $display("FAIL full_no_ack: got %b exp 0000", req_if.ack_o); end
    step();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall_256: got %b exp 1", stall); end
    for (int i = 0; i < 43; i++) step();
    checks++; if (stall !== 1'b1 || busy !== 1'b1 || ring_out !== exp_ring) begin errors++; $display("FAIL full_sat: got stall=%b busy=%b ring=%h", stall, busy, ring_out); end
    ring_in = '0;
    #1;
    checks++; if (req_if.ack_o !== 4'b0010) begin errors++; $display("FAIL full_regrant: got %b exp 0010", req_if.ack_o); end
    step();
    req_if.req_i = '0;
    checks++; if (ring_out.did !== 6'd7 || ring_out.sid !== NODE_ID || ring_out.data !== 32'h7777_0000) begin errors++; $display("FAIL full_inject: got %h exp did=7", ring_out); end
    checks++; if (stall !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_after: got stall=%b busy=%b exp 0/1", stall, busy); end
    step();
    checks++; if (ring_out.did !== 6'd9) begin errors++; $display("FAIL full_second: got %0d exp 9", ring_out.did); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_pkt(2'd0, 6'd10, 32'h10);
    drive_pkt(2'd1, 6'd11, 32'h11);
    req_if.req_i = 4'b0011;
    #1;
    checks++; if (req_if.ack_o !== 4'b0001) begin errors++; $display("FAIL b2b_ack0: got %b exp 0001", req_if.ack_o); end
    step();
    checks++; if (req_if.ack_o !== 4'b0010) begin errors++; $display("FAIL b2b_ack1: got %b exp 0010", req_if.ack_o); end
    step();
    req_if.req_i = '0;
    checks++; if (ring_out.did !== 6'd10) begin errors++; $display("FAIL b2b_out0: got %0d exp 10", ring_out.did); end
    step();
    checks++; if (ring_out.did !== 6'd11 || busy !== 1'b0) begin errors++; $display("FAIL b2b_out1: got did=%0d busy=%b exp 11/0", ring_out.did, busy); end
  endtask

  task automatic test_drop();
    do_reset();
    drive_pkt(2'd0, 6'd0, 32'hDEAD_0000);
    req_if.req_i = 4'b0001;
    #1;
    checks++; if (req_if.ack_o !== 4'b0001) begin errors++; $display("FAIL drop_ack: got %b exp 0001", req_if.ack_o); end
    step();
    req_if.req_i = '0;
    checks++; if (busy !== 1'b0 || state !== IDLE) begin errors++; $display("FAIL drop_busy: got busy=%b st=%0d exp 0/0", busy, state); end
    checks++; if (drop_cnt !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL drop_cnt: got %0d exp %0d", drop_cnt, STATS); end
    drive_pkt(2'd0, 6'd3, 32'h3);
    drive_pkt(2'd1, 6'd4, 32'h4);
    req_if.req_i = 4'b0011;
    #1;
    checks++; if (req_if.ack_o !== 4'b0010) begin errors++; $display("FAIL drop_ptr: got %b exp 0010", req_if.ack_o); end
    step();
    req_if.req_i = '0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_ring(6'd5, 32'h5);
    drive_pkt(2'd0, 6'd20, 32'h20);
    req_if.req_i = 4'b0001;
    step();
    req_if.req_i = '0;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b exp 1", busy); end
    #2;
    rst = 1'b1;
    req_if.req_i = 4'b0001;
    #1;
    checks++; if (busy !== 1'b0 || ring_out !== packet_t'('0)) begin errors++; $display("FAIL areset_now: got busy=%b ring=%h exp 0/0", busy, ring_out); end
    checks++; if (req_if.ack_o !== 4'b0000) begin errors++; $display("FAIL areset_ack: got %b exp 0000", req_if.ack_o); end
    @(posedge clk);
    #1;
    req_if.req_i = '0;
    ring_in = '0;
    rst = 1'b0;
    step();
    step();
    checks++; if (ring_out !== packet_t'('0) || busy !== 1'b0) begin errors++; $display("FAIL areset_noinj: got ring=%h busy=%b exp 0/0", ring_out, busy); end
  endtask

  initial begin
    rst          = 1'b1;
    id           = NODE_ID;
    ring_in      = '0;
    req_if.req_i = '0;
    req_if.pkt_i = '0;
    test_reset();
    test_single();
    test_fairness();
    test_ring_full();
    test_back_to_back();
    test_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
